// File: rtl/bcd_bin_seq.sv
// bcd_bin_seq: iterative multi-digit BCD-to-binary converter.
// Consumes one BCD digit per clock, most significant first (acc = acc*10 + digit),
// with valid/ready handshakes on input and output and an invalid-digit flag.
// Optional build macro BCD_BIN_CLAMP_EN: when defined, a word containing any
// digit >9 reports bin_out as all-ones instead of the raw wrapped accumulation.
module bcd_bin_seq #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIN_W-1:0]    bin_out,
  output logic                err
);

  localparam int unsigned SR_W  = 4 * DIGITS;
  localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [SR_W-1:0]   sr, sr_nxt;
  logic [BIN_W-1:0]  acc, acc_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              err_acc, err_acc_nxt;
  logic [BIN_W-1:0]  bin_nxt;
  logic              err_nxt;
  logic              out_valid_nxt;
  logic [3:0]        top_digit;
  logic [BIN_W-1:0]  mac;
  logic              mac_err;

  // Multiply-accumulate of the current top digit; acc*10 = acc*8 + acc*2, wrapping.
  assign top_digit = sr[SR_W-1 -: 4];
  assign mac       = BIN_W'(acc << 3) + BIN_W'(acc << 1) + BIN_W'(top_digit);
  assign mac_err   = (top_digit > 4'd9);

  // Ready is a decode of the state register, forced low while reset is asserted.
  assign in_ready = rst_n & (state == IDLE);

  // Next-state and datapath update.
  always_comb begin
    state_nxt     = state;
    sr_nxt        = sr;
    acc_nxt       = acc;
    cnt_nxt       = cnt;
    err_acc_nxt   = err_acc;
    bin_nxt       = bin_out;
    err_nxt       = err;
    out_valid_nxt = out_valid;
    case (state)
      IDLE: begin
        if (in_valid) begin
          sr_nxt      = bcd_in;
          acc_nxt     = '0;
          cnt_nxt     = '0;
          err_acc_nxt = 1'b0;
          state_nxt   = CONV;
        end
      end
      CONV: begin
        acc_nxt     = mac;
        err_acc_nxt = err_acc | mac_err;
        sr_nxt      = sr << 4;
        cnt_nxt     = cnt + CNT_W'(1);
        if (cnt == CNT_W'(DIGITS - 1)) begin
`ifdef BCD_BIN_CLAMP_EN
          bin_nxt = err_acc_nxt ? {BIN_W{1'b1}} : mac;
`else
          bin_nxt = mac;
`endif
          err_nxt       = err_acc_nxt;
          out_valid_nxt = 1'b1;
          cnt_nxt       = '0;
          state_nxt     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: begin
        out_valid_nxt = 1'b0;
        state_nxt     = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr        <= '0;
      acc       <= '0;
      cnt       <= '0;
      err_acc   <= 1'b0;
      bin_out   <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      sr        <= sr_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      err_acc   <= err_acc_nxt;
      bin_out   <= bin_nxt;
      err       <= err_nxt;
      out_valid <= out_valid_nxt;
    end
  end

endmodule
